// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared source IDs, arbiter state encoding and the fixed inst transfer size
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} arb_state_e;
    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;
    localparam logic [2:0] SIZE_WORD = 3'd2;
endpackage

// File: rtl/arb_id_fifo.sv
// arb_id_fifo: in-order FIFO of 1-bit source IDs for outstanding accepted requests
module arb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;
    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign head  = mem_q[rptr_q];
    always_comb begin
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin 2:1 arbiter of inst/data SRAM-like requests onto one slave port,
// routing in-order responses back through an ID FIFO.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [3:0]  m_wstrb,
    output logic [2:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);
    arb_state_e state_q, state_d;
    logic last_grant_q, last_grant_d;
    logic err_underflow;
    logic gnt_i, gnt_d, accept, pop;
    logic fifo_full, fifo_empty, fifo_head;
    always_comb begin
        gnt_i = state_q == LOCK_I ? inst_req :
                state_q == IDLE   ? inst_req & (~data_req | last_grant_q == SRC_DATA) : 1'b0;
        gnt_d = state_q == LOCK_D ? data_req :
                state_q == IDLE   ? data_req & (~inst_req | last_grant_q == SRC_INST) : 1'b0;
        m_req = (gnt_i | gnt_d) & ~fifo_full;
        accept = m_req & m_addr_ok;
        last_grant_d = accept ? (gnt_d ? SRC_DATA : SRC_INST) : last_grant_q;
        // A locked requester dropping its req is a protocol violation; fall back to IDLE.
        state_d = state_q != IDLE ? ((accept | ~(gnt_i | gnt_d)) ? IDLE : state_q) :
                  (m_req & ~m_addr_ok) ? (gnt_d ? LOCK_D : LOCK_I) : IDLE;
    end
    assign m_addr  = gnt_d ? data_addr : gnt_i ? inst_addr : '0;
    assign m_wr    = gnt_d & data_wr;
    assign m_wstrb = gnt_d ? data_wstrb : '0;
    assign m_size  = gnt_d ? data_size : gnt_i ? SIZE_WORD : '0;
    assign m_wdata = gnt_d ? data_wdata : '0;
    assign inst_addr_ok = gnt_i & accept;
    assign data_addr_ok = gnt_d & accept;
    assign pop          = m_data_ok & ~fifo_empty;
    assign inst_data_ok = pop & (fifo_head == SRC_INST);
    assign data_data_ok = pop & (fifo_head == SRC_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            last_grant_q  <= SRC_INST;
            err_underflow <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            err_underflow <= err_underflow | (m_data_ok & fifo_empty);
        end
    end
    arb_id_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (pop),
        .din    (gnt_d ? SRC_DATA : SRC_INST),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (fifo_head)
    );
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed bench with a response-ID scoreboard for mem_req_arbiter
module tb_mem_req_arbiter;
    import mem_arb_pkg::*;
    logic        clk = 1'b0, resetn;
    logic        inst_req, data_req, data_wr, m_addr_ok, m_data_ok;
    logic [31:0] inst_addr, data_addr, data_wdata, m_rdata;
    logic [3:0]  data_wstrb;
    logic [2:0]  data_size;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata, m_addr, m_wdata;
    logic        m_req, m_wr;
    logic [3:0]  m_wstrb;
    logic [2:0]  m_size;
    int n_chk = 0, n_fail = 0;
    logic exp_q[$];

    mem_req_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_wstrb(m_wstrb), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic clr_in;
        inst_req = 0; data_req = 0; data_wr = 0; m_addr_ok = 0; m_data_ok = 0;
        inst_addr = '0; data_addr = '0; data_wdata = '0; m_rdata = '0;
        data_wstrb = '0; data_size = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {19'b0, m_req, m_wr, m_wstrb, m_size,
                            inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'h0);
        chk({tag, "_maddr"}, m_addr, 32'h0);
        chk({tag, "_mwdata"}, m_wdata, 32'h0);
        chk({tag, "_irdata"}, inst_rdata, 32'h0);
        chk({tag, "_drdata"}, data_rdata, 32'h0);
    endtask

    task automatic expect_resp(input string tag);
        logic e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s: observed a response slot, expected an outstanding ID", tag);
        end else begin
            e = exp_q.pop_front();
            chk1({tag, "_iok"}, inst_data_ok, e == SRC_INST);
            chk1({tag, "_dok"}, data_data_ok, e == SRC_DATA);
        end
    endtask

    task automatic drain(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            m_data_ok = 1;
            m_rdata = $urandom;
            settle;
            expect_resp(tag);
            chk({tag, "_irdata"}, inst_rdata, m_rdata);
            chk({tag, "_drdata"}, data_rdata, m_rdata);
            tick;
        end
        m_data_ok = 0;
    endtask

    initial begin
        clr_in;
        resetn = 0;
        tick;
        tick;
        settle;
        chk_zero("rst");
        chk("rst_count", 32'(dut.u_fifo.count_q), 32'd0);
        chk1("rst_err", dut.err_underflow, 1'b0);
        chk1("rst_last", dut.last_grant_q, SRC_INST);
        resetn = 1;
        tick;

        // Inst only
        inst_req = 1; inst_addr = 32'hBFC0_0000; m_addr_ok = 1;
        settle;
        chk1("i_mreq", m_req, 1'b1);
        chk("i_maddr", m_addr, 32'hBFC0_0000);
        chk("i_msize", 32'(m_size), 32'd2);
        chk1("i_mwr", m_wr, 1'b0);
        chk1("i_iaok", inst_addr_ok, 1'b1);
        chk1("i_daok", data_addr_ok, 1'b0);
        exp_q.push_back(SRC_INST);
        tick;
        clr_in;
        settle;
        chk1("i_gap_iok", inst_data_ok, 1'b0);
        chk1("i_gap_dok", data_data_ok, 1'b0);
        tick;
        m_data_ok = 1; m_rdata = 32'h3C1D_0000;
        settle;
        expect_resp("i_resp");
        chk("i_rdata", inst_rdata, 32'h3C1D_0000);
        tick;
        clr_in;

        // Contention: data first, then alternate
        inst_req = 1; inst_addr = 32'h0000_A000;
        data_req = 1; data_addr = 32'h0000_D000; data_wr = 1; data_wstrb = 4'hF;
        data_size = 3'd2; data_wdata = 32'h1234_5678; m_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            logic s;
            s = (k % 2 == 0) ? SRC_DATA : SRC_INST;
            settle;
            chk("cont_addr", m_addr, s ? 32'h0000_D000 : 32'h0000_A000);
            chk("cont_wdata", m_wdata, s ? 32'h1234_5678 : 32'h0);
            chk1("cont_wr", m_wr, s);
            chk1("cont_iaok", inst_addr_ok, !s);
            chk1("cont_daok", data_addr_ok, s);
            exp_q.push_back(s);
            tick;
        end
        clr_in;
        drain(4, "cont_resp");

        // Lock: data accepted first so inst would win a fresh contention
        data_req = 1; data_addr = 32'h8000_0100; data_size = 3'd2; m_addr_ok = 1;
        settle;
        chk1("lk_pre_daok", data_addr_ok, 1'b1);
        exp_q.push_back(SRC_DATA);
        tick;
        data_addr = 32'h8000_0200; m_addr_ok = 0; inst_addr = 32'h0000_A100;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) inst_req = 1;
            settle;
            chk("lk_addr", m_addr, 32'h8000_0200);
            chk1("lk_mreq", m_req, 1'b1);
            chk1("lk_iaok", inst_addr_ok, 1'b0);
            chk1("lk_daok", data_addr_ok, 1'b0);
            tick;
        end
        m_addr_ok = 1;
        settle;
        chk1("lk_acc_daok", data_addr_ok, 1'b1);
        chk1("lk_acc_iaok", inst_addr_ok, 1'b0);
        exp_q.push_back(SRC_DATA);
        tick;
        data_req = 0;
        settle;
        chk("lk_next_addr", m_addr, 32'h0000_A100);
        chk1("lk_next_iaok", inst_addr_ok, 1'b1);
        exp_q.push_back(SRC_INST);
        tick;
        clr_in;
        drain(3, "lk_resp");

        // Full FIFO
        inst_req = 1; inst_addr = 32'h0000_B000; m_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            settle;
            chk1("full_fill_iaok", inst_addr_ok, 1'b1);
            exp_q.push_back(SRC_INST);
            tick;
        end
        settle;
        chk1("full_mreq", m_req, 1'b0);
        chk1("full_iaok", inst_addr_ok, 1'b0);
        chk("full_count", 32'(dut.u_fifo.count_q), 32'd4);
        m_data_ok = 1; m_rdata = 32'h0BAD_F00D;
        settle;
        expect_resp("full_pop");
        chk1("full_pop_mreq", m_req, 1'b0);
        tick;
        m_data_ok = 0;
        settle;
        chk1("full_reassert", m_req, 1'b1);
        chk1("full_reassert_iaok", inst_addr_ok, 1'b1);
        exp_q.push_back(SRC_INST);
        tick;
        clr_in;
        drain(4, "full_resp");

        // Ordering with simultaneous push and pop
        inst_req = 1; inst_addr = 32'h0000_C000; m_addr_ok = 1;
        settle;
        chk1("ord_iaok", inst_addr_ok, 1'b1);
        exp_q.push_back(SRC_INST);
        tick;
        inst_req = 0; data_req = 1; data_addr = 32'h0000_E000;
        for (int k = 0; k < 2; k++) begin
            settle;
            chk1("ord_daok", data_addr_ok, 1'b1);
            exp_q.push_back(SRC_DATA);
            tick;
        end
        data_req = 0; inst_req = 1; m_data_ok = 1; m_rdata = 32'h1111_2222;
        settle;
        chk("ord_count_pre", 32'(dut.u_fifo.count_q), 32'd3);
        expect_resp("ord_simul");
        chk1("ord_simul_iaok", inst_addr_ok, 1'b1);
        exp_q.push_back(SRC_INST);
        tick;
        clr_in;
        settle;
        chk("ord_count_post", 32'(dut.u_fifo.count_q), 32'd3);
        drain(3, "ord_resp");

        // Reset with IDs outstanding, then late response
        chk1("pre_err", dut.err_underflow, 1'b0);
        inst_req = 1; inst_addr = 32'h0000_F000; m_addr_ok = 1;
        tick;
        inst_req = 0; data_req = 1; data_addr = 32'h0000_F100;
        tick;
        clr_in;
        settle;
        chk("rs_count_pre", 32'(dut.u_fifo.count_q), 32'd2);
        resetn = 0;
        #1;
        chk("rs_count_async", 32'(dut.u_fifo.count_q), 32'd0);
        chk_zero("rs_in");
        exp_q.delete();
        tick;
        tick;
        resetn = 1;
        tick;
        m_data_ok = 1; m_rdata = 32'hDEAD_BEEF;
        settle;
        chk1("uf_iok", inst_data_ok, 1'b0);
        chk1("uf_dok", data_data_ok, 1'b0);
        tick;
        clr_in;
        settle;
        chk1("uf_err", dut.err_underflow, 1'b1);
        chk("uf_count", 32'(dut.u_fifo.count_q), 32'd0);
        chk_zero("uf_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Two-to-one arbiter for the SRAM-like memory request interface. It sits between the CPU core's instruction and data ports and the single SRAM-like slave port of the AXI bridge. It grants one requester at a time with round-robin priority and holds each grant stable until the address is accepted. It also records the source of every accepted request in an in-order ID FIFO, so that each response (`data_ok`/`rdata`) is routed back to the requester that issued it.

## Interface
- `DEPTH`, 4: maximum outstanding accepted-but-unanswered requests; power of two, ≥2.
- `clk` in 1: single clock; all state is updated on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `inst_req` in 1, `inst_addr` in 32: instruction read request, held until `inst_addr_ok`.
- `inst_addr_ok` out 1, `inst_data_ok` out 1, `inst_rdata` out 32: instruction handshake and return data.
- `data_req` in 1, `data_wr` in 1, `data_wstrb` in 4, `data_size` in 3, `data_addr` in 32, `data_wdata` in 32: data request, held until `data_addr_ok`.
- `data_addr_ok` out 1, `data_data_ok` out 1, `data_rdata` out 32: data handshake and return data.
- `m_req` out 1, `m_wr` out 1, `m_wstrb` out 4, `m_size` out 3, `m_addr` out 32, `m_wdata` out 32: downstream request.
- `m_addr_ok` in 1, `m_data_ok` in 1, `m_rdata` in 32: downstream handshake and return data. The downstream slave returns responses in order.

## Operation
- FSM states:
  - IDLE: no request is pending at the slave.
  - LOCK_I: the instruction request was presented and not yet accepted.
  - LOCK_D: the data request was presented and not yet accepted.
- Grant in IDLE:
  - Only one requester active: that requester wins.
  - Both active: the requester not granted last wins.
  - `last_grant` resets to INST, so the first contention goes to data.
- A grant is effective only when `count < DEPTH`. When the FIFO is full, `m_req` is 0 and the FSM stays in IDLE.
- Effective grant with `m_addr_ok` = 1 in the same cycle: the request is accepted; the FSM stays in IDLE and `last_grant` updates.
- Effective grant with `m_addr_ok` = 0: the FSM enters LOCK_x. While locked, the same source stays granted and the other requester is ignored.
- LOCK_x exits to IDLE on `m_addr_ok`, at which point `last_grant` updates.
- Locked requester drops its req (illegal under the protocol): return to IDLE and push nothing.
- Mux when inst is granted: `m_addr` = `inst_addr`, `m_wr` = 0, `m_wstrb` = 0, `m_size` = 3'd2, `m_wdata` = 0.
- Mux when data is granted: the data fields pass through unchanged.
- `x_addr_ok` = granted & `m_req` & `m_addr_ok`. The non-granted requester sees 0.
- Accept (`m_req` & `m_addr_ok`): push the source ID (0 = inst, 1 = data).
- `m_data_ok`: pop the head entry. Drive `x_data_ok` = 1 for the source at the head; the other requester sees 0.
- `inst_rdata` and `data_rdata` both equal `m_rdata` unconditionally.
- `m_data_ok` while the FIFO is empty is a protocol error:
  - no upstream `data_ok` is raised;
  - `count` stays 0;
  - the sticky internal flag `err_underflow` is set and is visible to the bench.
- Push and pop in the same cycle are both applied, so `count` is unchanged. A response never belongs to a request accepted in that same cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits.

## Timing
- The upstream request to `m_req`/`m_addr` path is combinational, so there is zero added latency.
- The `m_addr_ok` to `x_addr_ok` path is combinational.
- `m_data_ok`/`m_rdata` to `x_data_ok`/`x_rdata` is combinational through the FIFO head, with zero added latency.
- Reset values:
  - FSM = IDLE, `last_grant` = INST, FIFO pointers and `count` = 0, `err_underflow` = 0.
  - With no requests active, every output is 0.
- Reset asserted mid-transaction discards all outstanding IDs. A late `m_data_ok` after reset counts as underflow.
- Throughput: one accept per cycle when `m_addr_ok` is continuously high and the FIFO is not full.

## Structure
- Package `mem_arb_pkg`:
  - source IDs `SRC_INST` = 1'b0 and `SRC_DATA` = 1'b1;
  - state encoding for IDLE, LOCK_I and LOCK_D;
  - size constant `SIZE_WORD` = 3'd2.
- Sub-module `arb_id_fifo`: synchronous FIFO, width 1, depth `DEPTH`, asynchronous active-low reset, with outputs `full`, `empty` and `head`.
- The top level contains the FSM, the round-robin pointer and the mux.

## Test plan
- Inst only: `inst_req` to 0xBFC00000 with `m_addr_ok` = 1, then `m_data_ok` two cycles later with `m_rdata` = 0x3C1D0000 → `inst_addr_ok` in the same cycle, `inst_data_ok` with rdata 0x3C1D0000, `data_data_ok` never rises.
- Contention: both requesting from reset with `m_addr_ok` = 1 → grant order data, inst, data, inst, and `m_addr` alternates every cycle.
- Lock: data granted with `m_addr_ok` = 0 for 3 cycles while `inst_req` rises → `m_addr` stays the data address and `inst_addr_ok` = 0 throughout; inst is granted in the cycle after the data accept.
- Full: `DEPTH` = 4, 4 accepts with no `m_data_ok` → 5th request sees `m_req` = 0; one `m_data_ok` pops the FIFO and `m_req` reasserts the next cycle.
- Ordering: accept inst, data, data, then 3 × `m_data_ok` → `inst_data_ok`, `data_data_ok`, `data_data_ok` in that order; a simultaneous accept and pop leaves `count` unchanged.
- Reset and underflow: assert `resetn` = 0 with 2 IDs outstanding, release, then drive `m_data_ok` → no upstream `data_ok`, `err_underflow` = 1, all outputs 0 during reset.
